// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII receive deframer: FSM encoding, framing bytes and the
// CRC-32 constants. The helper folds one byte into an MSB-first CRC register, LSB of the byte first.
package gmii_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StDrop
  } rx_state_e;

  localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
  localparam logic [7:0]  GMII_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] crc32_step8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 register with synchronous init and enable. Over a frame that
// includes its FCS the register settles at CRC32_RESIDUE.
module crc32_d8
  import gmii_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_d, crc_q;

  always_comb begin
    crc_d = crc_q;
    if (init_i)    crc_d = '1;
    else if (en_i) crc_d = crc32_step8(crc_q, data_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= '1;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, delays frame bytes by one to flag eof, runt-checks
// and counts frames. Define GMII_RX_DEFRAMER_CRC_CHECK_EN to add the FCS residue check.
module gmii_rx_deframer
  import gmii_pkg::*;
#(
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_PREAMBLE  = 7
) (
  input  logic        gmii_rxclk,
  input  logic        rst_n,
  input  logic        gmii_rxctrl,
  input  logic [7:0]  gmii_rxdata,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_err,
  output logic [15:0] rx_len,
  output logic [31:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int unsigned PreW = (MAX_PREAMBLE < 2) ? 1 : $clog2(MAX_PREAMBLE + 1);

  rx_state_e       state_d, state_q;
  logic [PreW-1:0] pre_cnt_d, pre_cnt_q;
  logic [7:0]      hold_d, hold_q;
  logic            hold_vld_d, hold_vld_q;
  logic            sof_pend_d, sof_pend_q;
  logic [15:0]     len_d, len_q;
  logic            valid_d, valid_q, sof_d, sof_q, eof_d, eof_q, err_d, err_q;
  logic [7:0]      data_d, data_q;
  logic [15:0]     rx_len_d, rx_len_q;
  logic [31:0]     frame_cnt_d, frame_cnt_q;
  logic [15:0]     drop_cnt_d, drop_cnt_q;
  logic            drop_inc, crc_err, frame_err;

`ifdef GMII_RX_DEFRAMER_CRC_CHECK_EN
  logic [31:0] crc_val;

  crc32_d8 u_crc (
    .clk_i  (gmii_rxclk),
    .rst_ni (rst_n),
    .init_i (state_q != StData),
    .en_i   ((state_q == StData) && gmii_rxctrl),
    .data_i (gmii_rxdata),
    .crc_o  (crc_val)
  );

  assign crc_err = (crc_val != CRC32_RESIDUE);
`else
  assign crc_err = 1'b0;
`endif

  assign frame_err = (len_q < 16'(MIN_FRAME_LEN)) || crc_err;

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    sof_pend_d  = sof_pend_q;
    len_d       = len_q;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    err_d       = 1'b0;
    data_d      = data_q;
    rx_len_d    = rx_len_q;
    frame_cnt_d = frame_cnt_q;
    drop_inc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        hold_vld_d = 1'b0;
        if (gmii_rxctrl) begin
          if (gmii_rxdata == GMII_PREAMBLE) begin
            state_d   = StPreamble;
            pre_cnt_d = PreW'(1);
          end else begin
            state_d  = StDrop;
            drop_inc = 1'b1;
          end
        end
      end
      StPreamble: begin
        if (!gmii_rxctrl) begin
          state_d  = StIdle;
          drop_inc = 1'b1;
        end else if (gmii_rxdata == GMII_PREAMBLE) begin
          if (pre_cnt_q < PreW'(MAX_PREAMBLE)) begin
            pre_cnt_d = pre_cnt_q + 1'b1;
          end else begin
            state_d  = StDrop;
            drop_inc = 1'b1;
          end
        end else if (gmii_rxdata == GMII_SFD) begin
          state_d    = StData;
          hold_vld_d = 1'b0;
          sof_pend_d = 1'b1;
          len_d      = '0;
        end else begin
          state_d  = StDrop;
          drop_inc = 1'b1;
        end
      end
      StData: begin
        // The held byte goes out only once we know whether another byte follows it.
        if (hold_vld_q) begin
          valid_d = 1'b1;
          data_d  = hold_q;
          sof_d   = sof_pend_q;
        end
        if (gmii_rxctrl) begin
          if (hold_vld_q) sof_pend_d = 1'b0;
          hold_d     = gmii_rxdata;
          hold_vld_d = 1'b1;
          if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
        end else begin
          state_d    = StIdle;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            eof_d    = 1'b1;
            err_d    = frame_err;
            rx_len_d = len_q;
            if (!frame_err) frame_cnt_d = frame_cnt_q + 32'd1;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      StDrop: begin
        if (!gmii_rxctrl) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    drop_cnt_d = (drop_inc && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge gmii_rxclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pre_cnt_q   <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      sof_pend_q  <= 1'b0;
      len_q       <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      rx_len_q    <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      sof_pend_q  <= sof_pend_d;
      len_q       <= len_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      err_q       <= err_d;
      data_q      <= data_d;
      rx_len_q    <= rx_len_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign rx_valid  = valid_q;
  assign rx_data   = data_q;
  assign rx_sof    = sof_q;
  assign rx_eof    = eof_q;
  assign rx_err    = err_q;
  assign rx_len    = rx_len_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Self-checking bench for gmii_rx_deframer: random payloads, reference frame model with a
// reflected-table-free bitwise Ethernet FCS, and directed preamble/reset scenarios.
module tb_gmii_rx_deframer;

  localparam int unsigned MinLen = 64;
  localparam int unsigned MaxPre = 7;
`ifdef GMII_RX_DEFRAMER_CRC_CHECK_EN
  localparam bit CrcEn = 1'b1;
`else
  localparam bit CrcEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        gmii_rxctrl = 1'b0;
  logic [7:0]  gmii_rxdata = 8'h00;
  logic        rx_valid, rx_sof, rx_eof, rx_err;
  logic [7:0]  rx_data;
  logic [15:0] rx_len, drop_cnt;
  logic [31:0] frame_cnt;

  gmii_rx_deframer #(
    .MIN_FRAME_LEN (MinLen),
    .MAX_PREAMBLE  (MaxPre)
  ) dut (
    .gmii_rxclk  (clk),
    .rst_n       (rst_n),
    .gmii_rxctrl (gmii_rxctrl),
    .gmii_rxdata (gmii_rxdata),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_sof      (rx_sof),
    .rx_eof      (rx_eof),
    .rx_err      (rx_err),
    .rx_len      (rx_len),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #4 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_frames = '0;
  logic [15:0] exp_drops  = '0;
  logic [15:0] exp_len    = '0;
  logic [7:0]  pl[$];
  // Entries are {data, sof, eof, err-at-eof}.
  logic [10:0] mon_q[$];
  logic [10:0] exp_q[$];

  always @(negedge clk) begin
    if (rx_valid) mon_q.push_back({rx_data, rx_sof, rx_eof, rx_eof & rx_err});
  end

  function automatic logic [31:0] eth_fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, pl[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic drive(input logic c, input logic [7:0] d);
    gmii_rxctrl = c;
    gmii_rxdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    repeat (3) drive(1'b0, 8'h00);
  endtask

  task automatic clear();
    mon_q.delete();
    exp_q.delete();
  endtask

  // fcs_mode: 0 = raw bytes, 1 = append good FCS, 2 = append FCS with one bit flipped.
  task automatic make_payload(input int n, input int fcs_mode);
    logic [31:0] f;
    int          k;
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    if (fcs_mode != 0) begin
      f = eth_fcs(n);
      pl.push_back(f[7:0]);
      pl.push_back(f[15:8]);
      pl.push_back(f[23:16]);
      pl.push_back(f[31:24]);
      if (fcs_mode == 2) begin
        k = $urandom_range(n + 3, n);
        pl[k] = pl[k] ^ (8'h01 << $urandom_range(7, 0));
      end
    end
  endtask

  task automatic send_frame(input int npre, input bit sfd);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
    if (sfd) drive(1'b1, 8'hD5);
    foreach (pl[i]) drive(1'b1, pl[i]);
    drive(1'b0, 8'h00);
  endtask

  // Expected outcome of a frame with a well-formed preamble carrying payload pl.
  task automatic model_frame();
    int          n;
    bit          crc_ok, err;
    logic [31:0] f;
    n = pl.size();
    if (n == 0) begin
      exp_drops = exp_drops + 16'd1;
      return;
    end
    crc_ok = 1'b0;
    if (n >= 4) begin
      f = eth_fcs(n - 4);
      crc_ok = ({pl[n-1], pl[n-2], pl[n-3], pl[n-4]} == f);
    end
    err = (n < MinLen) || (CrcEn && !crc_ok);
    for (int i = 0; i < n; i++) exp_q.push_back({pl[i], i == 0, i == n - 1, (i == n - 1) && err});
    if (!err) exp_frames = exp_frames + 32'd1;
    exp_len = 16'(n);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_tests += 8;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, want 0", rx_valid); end
    if (rx_sof !== 1'b0) begin n_fail++; $display("FAIL reset_sof: got %b, want 0", rx_sof); end
    if (rx_eof !== 1'b0) begin n_fail++; $display("FAIL reset_eof: got %b, want 0", rx_eof); end
    if (rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, want 0", rx_err); end
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, want 00", rx_data); end
    if (rx_len !== 16'h0) begin n_fail++; $display("FAIL reset_len: got %0d, want 0", rx_len); end
    if (frame_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_frames: got %0d, want 0", frame_cnt); end
    if (drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drops: got %0d, want 0", drop_cnt); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    flush();
  endtask

  task automatic test_good_frame();
    clear();
    make_payload(60, 1);
    model_frame();
    send_frame(7, 1'b1);
    flush();
    n_tests++;
    if (mon_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL good_count: got %0d bytes, want %0d", mon_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++;
      if (mon_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL good_byte[%0d]: got %h, want %h", i, mon_q[i], exp_q[i]);
      end
    end
    n_tests += 3;
    if (rx_len !== 16'd64) begin n_fail++; $display("FAIL good_len: got %0d, want 64", rx_len); end
    if (frame_cnt !== 32'd1) begin n_fail++; $display("FAIL good_frames: got %0d, want 1", frame_cnt); end
    if (exp_frames !== 32'd1) begin n_fail++; $display("FAIL good_model: got %0d, want 1", exp_frames); end
  endtask

  task automatic test_runt();
    clear();
    pl.delete();
    pl.push_back(8'hAA);
    pl.push_back(8'hBB);
    pl.push_back(8'hCC);
    model_frame();
    send_frame(1, 1'b1);
    flush();
    n_tests++;
    if (mon_q.size() != 3) begin
      n_fail++; $display("FAIL runt_count: got %0d bytes, want 3", mon_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++;
      if (mon_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL runt_byte[%0d]: got %h, want %h", i, mon_q[i], exp_q[i]);
      end
    end
    n_tests += 2;
    if (rx_len !== 16'd3) begin n_fail++; $display("FAIL runt_len: got %0d, want 3", rx_len); end
    if (frame_cnt !== exp_frames) begin
      n_fail++; $display("FAIL runt_frames: got %0d, want %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_long_preamble();
    clear();
    make_payload(10, 0);
    exp_drops = exp_drops + 16'd1;
    send_frame(8, 1'b1);
    flush();
    n_tests += 3;
    if (mon_q.size() != 0) begin n_fail++; $display("FAIL longpre_out: got %0d bytes, want 0", mon_q.size()); end
    if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL longpre_drops: got %0d, want 1", drop_cnt); end
    if (frame_cnt !== exp_frames) begin
      n_fail++; $display("FAIL longpre_frames: got %0d, want %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_bad_fcs();
    clear();
    make_payload(60, 2);
    model_frame();
    send_frame(7, 1'b1);
    flush();
    n_tests++;
    if (mon_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL badfcs_count: got %0d bytes, want %0d", mon_q.size(), exp_q.size());
    end else begin
      n_tests++;
      if (mon_q[63] !== exp_q[63]) begin
        n_fail++; $display("FAIL badfcs_eof: got %h, want %h", mon_q[63], exp_q[63]);
      end
    end
    n_tests++;
    if (frame_cnt !== exp_frames) begin
      n_fail++; $display("FAIL badfcs_frames: got %0d, want %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    clear();
    base = frame_cnt;
    make_payload(60, 1);
    model_frame();
    send_frame(7, 1'b1);
    make_payload(60, 1);
    model_frame();
    send_frame(7, 1'b1);
    flush();
    n_tests++;
    if (mon_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d bytes, want %0d", mon_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++;
      if (mon_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_byte[%0d]: got %h, want %h", i, mon_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (frame_cnt !== base + 32'd2) begin
      n_fail++; $display("FAIL b2b_frames: got %0d, want %0d", frame_cnt, base + 32'd2);
    end
  endtask

  task automatic test_random();
    int kind, mism;
    clear();
    mism = 0;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(6, 0);
      case (kind)
        0, 1, 2: begin
          make_payload($urandom_range(100, 1), (kind == 0) ? 0 : kind);
          model_frame();
          send_frame($urandom_range(MaxPre, 1), 1'b1);
        end
        3: begin
          make_payload($urandom_range(20, 2), 0);
          exp_drops = exp_drops + 16'd1;
          send_frame($urandom_range(MaxPre + 3, MaxPre + 1), 1'b1);
        end
        4: begin
          make_payload($urandom_range(20, 1), 0);
          if (pl[0] == 8'h55) pl[0] = 8'h00;
          exp_drops = exp_drops + 16'd1;
          send_frame(0, 1'b0);
        end
        5: begin
          make_payload($urandom_range(20, 1), 0);
          if (pl[0] == 8'h55 || pl[0] == 8'hD5) pl[0] = 8'h12;
          exp_drops = exp_drops + 16'd1;
          send_frame($urandom_range(MaxPre - 1, 1), 1'b0);
        end
        default: begin
          pl.delete();
          model_frame();
          send_frame($urandom_range(MaxPre, 1), 1'b1);
        end
      endcase
      if ($urandom_range(1, 0) == 1) drive(1'b0, 8'h00);
    end
    flush();
    n_tests++;
    if (mon_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d bytes, want %0d", mon_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      if (mon_q[i] !== exp_q[i]) mism++;
    end
    n_tests += 4;
    if (mism != 0) begin n_fail++; $display("FAIL rand_bytes: got %0d wrong entries, want 0", mism); end
    if (frame_cnt !== exp_frames) begin
      n_fail++; $display("FAIL rand_frames: got %0d, want %0d", frame_cnt, exp_frames);
    end
    if (drop_cnt !== exp_drops) begin
      n_fail++; $display("FAIL rand_drops: got %0d, want %0d", drop_cnt, exp_drops);
    end
    if (exp_q.size() != 0 && rx_len !== exp_len) begin
      n_fail++; $display("FAIL rand_len: got %0d, want %0d", rx_len, exp_len);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear();
    make_payload(60, 1);
    for (int i = 21; i < pl.size(); i++) if (pl[i] == 8'h55) pl[i] = 8'h54;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1'b1, pl[i]);
    rst_n = 1'b0;
    #1;
    n_tests += 5;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, want 0", rx_valid); end
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h, want 00", rx_data); end
    if (rx_sof !== 1'b0 || rx_eof !== 1'b0 || rx_err !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags: got %b%b%b, want 000", rx_sof, rx_eof, rx_err);
    end
    if (frame_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_frames: got %0d, want 0", frame_cnt); end
    if (drop_cnt !== 16'd0 || rx_len !== 16'd0) begin
      n_fail++; $display("FAIL midrst_cnt: got drops %0d len %0d, want 0 0", drop_cnt, rx_len);
    end
    mon_q.delete();
    exp_frames = '0;
    exp_drops  = '0;
    drive(1'b1, pl[20]);
    rst_n = 1'b1;
    for (int i = 21; i < pl.size(); i++) drive(1'b1, pl[i]);
    drive(1'b0, 8'h00);
    exp_drops = exp_drops + 16'd1;
    flush();
    n_tests += 2;
    if (mon_q.size() != 0) begin n_fail++; $display("FAIL midrst_tail: got %0d bytes, want 0", mon_q.size()); end
    if (drop_cnt !== exp_drops) begin
      n_fail++; $display("FAIL midrst_drops: got %0d, want %0d", drop_cnt, exp_drops);
    end
    clear();
    make_payload(60, 1);
    model_frame();
    send_frame(5, 1'b1);
    flush();
    n_tests++;
    if (mon_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midrst_next_count: got %0d, want %0d", mon_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++;
      if (mon_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL midrst_next[%0d]: got %h, want %h", i, mon_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (frame_cnt !== 32'd1) begin n_fail++; $display("FAIL midrst_next_frames: got %0d, want 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_runt();
    test_long_preamble();
    test_bad_fcs();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
